// File: rtl/clock_control_nch.sv
// N-channel clock-control core: sums elastic-buffer fill offsets each cycle and,
// once per settle period, issues a FINC/FDEC pulse train and updates a stability flag.
module clock_control_nch #(
  parameter int NUM_CHANNELS     = 2,
  parameter int COUNT_WIDTH      = 8,
  parameter int SETTLE_PERIOD    = 4096,
  parameter int PULSE_WIDTH      = 4,
  parameter int DEADBAND         = 2,
  parameter int STABLE_THRESHOLD = 4,
  parameter int STABLE_UPDATES   = 8,
  localparam int SW = COUNT_WIDTH + 1 + $clog2(NUM_CHANNELS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] data_counts,
  input  logic [NUM_CHANNELS-1:0]             channel_mask,
  input  logic [NUM_CHANNELS-1:0]             drain_fifo,
  output logic                                finc,
  output logic                                fdec,
  output logic                                is_stable,
  output logic                                update_strobe,
  output logic [SW-1:0]                       error_sum
);

  localparam int PCW = $clog2(SETTLE_PERIOD);
  localparam int SCW = $clog2(STABLE_UPDATES + 1);

  localparam logic [PCW-1:0] PERIOD_TC = PCW'(SETTLE_PERIOD - 1);
  localparam logic [7:0]     PULSE_LEN = 8'(PULSE_WIDTH);
  localparam logic [SCW-1:0] STABLE_MAX = SCW'(STABLE_UPDATES);

  localparam logic signed [SW-1:0] MID     = {{(SW-COUNT_WIDTH){1'b0}}, 1'b1, {(COUNT_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] POS_DB  = SW'(DEADBAND);
  localparam logic signed [SW-1:0] NEG_DB  = SW'(-DEADBAND);
  localparam logic signed [SW-1:0] POS_THR = SW'(STABLE_THRESHOLD);
  localparam logic signed [SW-1:0] NEG_THR = SW'(-STABLE_THRESHOLD);

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_INC  = 2'd1,
    P_DEC  = 2'd2
  } pulse_state_e;

  pulse_state_e           pulse_state_q, pulse_state_d;
  logic [PCW-1:0]         period_q, period_d;
  logic [7:0]             pulse_cnt_q, pulse_cnt_d;
  logic [SCW-1:0]         stable_cnt_q, stable_cnt_d;
  logic                   is_stable_q, is_stable_d;
  logic                   strobe_q, strobe_d;
  logic signed [SW-1:0]   sum_q, sum_d;
  logic                   tc;

  // Masked or draining channels contribute nothing; the rest contribute count - midpoint.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (channel_mask[i] && !drain_fifo[i]) begin
        sum_d = sum_d
              + $signed({{(SW-COUNT_WIDTH){1'b0}}, data_counts[i*COUNT_WIDTH +: COUNT_WIDTH]})
              - MID;
      end
    end
  end

  assign tc = (period_q == PERIOD_TC);

  always_comb begin
    period_d      = tc ? '0 : period_q + 1'b1;
    strobe_d      = (period_d == PERIOD_TC);
    pulse_state_d = pulse_state_q;
    pulse_cnt_d   = pulse_cnt_q;
    stable_cnt_d  = stable_cnt_q;
    if (tc) begin
      // sum_q during the TC cycle is the decision value.
      if (sum_q > POS_DB) begin
        pulse_state_d = P_INC;
        pulse_cnt_d   = PULSE_LEN;
      end else if (sum_q < NEG_DB) begin
        pulse_state_d = P_DEC;
        pulse_cnt_d   = PULSE_LEN;
      end else begin
        pulse_state_d = P_IDLE;
        pulse_cnt_d   = '0;
      end
      if (sum_q <= POS_THR && sum_q >= NEG_THR && !(|drain_fifo)) begin
        stable_cnt_d = (stable_cnt_q == STABLE_MAX) ? stable_cnt_q : stable_cnt_q + 1'b1;
      end else begin
        stable_cnt_d = '0;
      end
    end else if (pulse_cnt_q > 8'd1) begin
      pulse_cnt_d = pulse_cnt_q - 8'd1;
    end else begin
      pulse_cnt_d   = '0;
      pulse_state_d = P_IDLE;
    end
    is_stable_d = (stable_cnt_d == STABLE_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_state_q <= P_IDLE;
      period_q      <= '0;
      pulse_cnt_q   <= '0;
      stable_cnt_q  <= '0;
      is_stable_q   <= 1'b0;
      strobe_q      <= 1'b0;
      sum_q         <= '0;
    end else begin
      pulse_state_q <= pulse_state_d;
      period_q      <= period_d;
      pulse_cnt_q   <= pulse_cnt_d;
      stable_cnt_q  <= stable_cnt_d;
      is_stable_q   <= is_stable_d;
      strobe_q      <= strobe_d;
      sum_q         <= sum_d;
    end
  end

  assign finc          = (pulse_state_q == P_INC);
  assign fdec          = (pulse_state_q == P_DEC);
  assign is_stable     = is_stable_q;
  assign update_strobe = strobe_q;
  assign error_sum     = sum_q;

endmodule

// File: tb/tb_clock_control_nch.sv
// Directed plus randomized bench for clock_control_nch against a cycle-indexed
// arithmetic model of the decision, pulse and stability rules.
module tb_clock_control_nch;

  localparam int NC  = 4;
  localparam int CW  = 8;
  localparam int SP  = 16;
  localparam int PW  = 4;
  localparam int DB  = 2;
  localparam int THR = 4;
  localparam int SU  = 8;
  localparam int SW  = CW + 1 + $clog2(NC);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CW-1:0]   cnt [NC];
  logic [NC*CW-1:0] data_counts;
  logic [NC-1:0]   channel_mask = '0;
  logic [NC-1:0]   drain_fifo = '0;
  logic            finc, fdec, is_stable, update_strobe;
  logic [SW-1:0]   error_sum;

  int checks = 0;
  int errors = 0;

  // Model state: cycle index since reset release, registered sum, pulse cycles left, direction, stable count.
  int m_n = 0, m_sum = 0, m_left = 0, m_dir = 0, m_stab = 0, m_flag = 0;

  always #5 clk = ~clk;

  assign data_counts = {cnt[3], cnt[2], cnt[1], cnt[0]};

  clock_control_nch #(
    .NUM_CHANNELS(NC), .COUNT_WIDTH(CW), .SETTLE_PERIOD(SP), .PULSE_WIDTH(PW),
    .DEADBAND(DB), .STABLE_THRESHOLD(THR), .STABLE_UPDATES(SU)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_counts(data_counts), .channel_mask(channel_mask),
    .drain_fifo(drain_fifo), .finc(finc), .fdec(fdec), .is_stable(is_stable),
    .update_strobe(update_strobe), .error_sum(error_sum)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, m_n);
    end
  endtask

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < NC; i++)
      if (channel_mask[i] && !drain_fifo[i]) s += int'(cnt[i]) - (1 << (CW-1));
    return s;
  endfunction

  task automatic check_outputs();
    chk("error_sum", $signed(error_sum), m_sum);
    chk("finc", {31'd0, finc}, (m_left > 0 && m_dir > 0) ? 1 : 0);
    chk("fdec", {31'd0, fdec}, (m_left > 0 && m_dir < 0) ? 1 : 0);
    chk("is_stable", {31'd0, is_stable}, m_flag);
    chk("update_strobe", {31'd0, update_strobe}, (m_n % SP == SP-1) ? 1 : 0);
  endtask

  // One clock: advance the model by the rules for the cycle that just ended, then compare.
  task automatic step();
    int nsum;
    int d;
    nsum = model_sum();
    @(posedge clk);
    if (m_n % SP == SP-1) begin
      d = m_sum;
      if (d > DB) begin m_left = PW; m_dir = 1; end
      else if (d < -DB) begin m_left = PW; m_dir = -1; end
      else begin m_left = 0; m_dir = 0; end
      if (d <= THR && d >= -THR && drain_fifo == '0) m_stab = (m_stab < SU) ? m_stab + 1 : SU;
      else m_stab = 0;
      m_flag = (m_stab == SU) ? 1 : 0;
    end else if (m_left > 0) begin
      m_left--;
    end
    m_sum = nsum;
    m_n++;
    #1;
    check_outputs();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    m_n = 0; m_sum = 0; m_left = 0; m_dir = 0; m_stab = 0; m_flag = 0;
    chk("rst_finc", {31'd0, finc}, 0);
    chk("rst_fdec", {31'd0, fdec}, 0);
    chk("rst_is_stable", {31'd0, is_stable}, 0);
    chk("rst_strobe", {31'd0, update_strobe}, 0);
    chk("rst_error_sum", $signed(error_sum), 0);
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_all(input logic [CW-1:0] v);
    for (int i = 0; i < NC; i++) cnt[i] = v;
  endtask

  initial begin
    int steps;
    set_all(8'h80);
    channel_mask = 4'b0011;
    drain_fifo   = '0;

    // Reset and idle: balanced counts, stability after SU decisions.
    do_reset(10);
    run(SU*SP + 4);
    chk("idle_stable", {31'd0, is_stable}, 1);

    // Positive error.
    cnt[0] = 8'h90;
    run(2*SP);
    chk("pos_sum", $signed(error_sum), 16);

    // Negative beyond deadband, then exactly at deadband.
    cnt[0] = 8'h7F; cnt[1] = 8'h7E;
    run(2*SP);
    chk("neg_sum", $signed(error_sum), -3);
    cnt[1] = 8'h7F;
    run(2*SP);
    chk("db_sum", $signed(error_sum), -2);

    // Masked channel with extreme count.
    cnt[0] = 8'hFF; cnt[1] = 8'h80; channel_mask = 4'b0010;
    run(SU*SP + 2);
    chk("mask_sum", $signed(error_sum), 0);
    chk("mask_stable", {31'd0, is_stable}, 1);

    // Drain pulse that clears before TC leaves stability intact.
    while (m_n % SP != 3) step();
    drain_fifo = 4'b0010;
    run(4);
    drain_fifo = '0;
    run(SP);
    chk("drain_mid_stable", {31'd0, is_stable}, 1);

    // Drain held across TC drops stability.
    drain_fifo = 4'b0010;
    run(SP + 1);
    chk("drain_tc_stable", {31'd0, is_stable}, 0);
    drain_fifo = '0;

    // Extremes with all channels participating.
    channel_mask = 4'hF;
    set_all(8'h00);
    run(3);
    chk("ext_min", $signed(error_sum), -512);
    set_all(8'hFF);
    run(3);
    chk("ext_max", $signed(error_sum), 508);
    run(2*SP);

    // Randomized near-balanced traffic.
    for (int i = 0; i < 14*SP; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int c = 0; c < NC; c++) cnt[c] = 8'(122 + $urandom_range(0, 12));
        channel_mask = 4'($urandom_range(0, 15));
        drain_fifo   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      end
      step();
    end
    drain_fifo = '0;

    // Reset in the middle of a finc pulse.
    set_all(8'h80); cnt[0] = 8'h90; channel_mask = 4'b0001;
    steps = 0;
    while (!(m_left == PW-1 && m_dir > 0) && steps < 4*SP) begin
      step();
      steps++;
    end
    chk("mid_pulse_reached", {31'd0, finc}, 1);
    do_reset(3);
    steps = 0;
    while (update_strobe !== 1'b1 && steps < 2*SP) begin
      step();
      steps++;
    end
    chk("first_strobe_after_reset", steps, SP-1);
    run(SP + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
